// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer for a word-addressed, async-read ROM.
// It owns the fetch PC, drives imem_addr from that register, and captures each
// returned word with its PC. Words go to decode through a small FIFO that uses
// a valid/ready handshake. A redirect flushes the FIFO and restarts fetching.
// A HALT_WORD or an out-of-range PC stops fetching.
// Optional build macro: IFETCH_PERF_EN adds free-running fetch and stall counters.
// When the macro is undefined, both perf ports are tied to zero.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | after reset; waits for start, pc parked at RESET_PC
//   RUN   | fetching one word per cycle while the FIFO has a free slot
//   HALT  | fetching stopped (halt word or PC past ROM); FIFO drains
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_SIZE   = 256,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        halted,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic fetch;
  logic in_range;
  logic push;
  logic pop;
  logic unused_rpc_lsb;

  // The low two bits of the redirect target are not used because fetch is always word aligned.
  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // A pop does not free a slot in the same cycle. The fetch decision uses only the registered count.
  assign fetch    = (state == RUN) && (count < CW'(FIFO_DEPTH)) && !redirect_valid;
  assign in_range = (pc >> 2) < 32'(MEM_SIZE);
  assign push     = fetch && in_range;
  assign pop      = inst_valid && inst_ready && !redirect_valid;

  assign imem_addr  = pc;
  assign inst_valid = (count != '0);
  assign inst_data  = fifo_data[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];
  assign halted     = (state == HALT);

  // FSM, fetch PC and fetch FIFO. A redirect overrides every other update in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      state  <= RUN;
      pc     <= {redirect_pc[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= imem_data;
        fifo_pc[wr_ptr]   <= pc;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end

      unique case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          if (fetch) begin
            if (!in_range) begin
              state <= HALT;
            end else if (imem_data == HALT_WORD) begin
              // The halt word is still delivered. The PC stays on it.
              state <= HALT;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Free-running performance counters. They wrap naturally and a redirect does not clear them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (inst_valid && !inst_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl. A table of per-cycle vectors covers
// start, streaming, halt-word stop, redirect resume and back-pressure. Short
// hand-written sequences cover the odd-address redirect with a full FIFO,
// asynchronous reset, and the ROM range limit on a MEM_SIZE=4 instance.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_ready, inst_ready4;
  logic [31:0] imem_addr, imem_data, inst_data, inst_pc;
  logic [31:0] imem_addr4, imem_data4, inst_data4, inst_pc4;
  logic        inst_valid, halted, inst_valid4, halted4;
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_fetch_cnt4, perf_stall_cnt4;
  logic        redirect_valid4;
  logic [31:0] redirect_pc4;

  logic [31:0] rom [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb imem_data  = rom[imem_addr[9:2]];
  always_comb imem_data4 = rom[imem_addr4[9:2]];

  ifetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .halted(halted),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  ifetch_ctrl #(.MEM_SIZE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
    .imem_addr(imem_addr4), .imem_data(imem_data4),
    .inst_valid(inst_valid4), .inst_ready(inst_ready4),
    .inst_data(inst_data4), .inst_pc(inst_pc4), .halted(halted4),
    .perf_fetch_cnt(perf_fetch_cnt4), .perf_stall_cnt(perf_stall_cnt4)
  );

  typedef struct {
    logic        start;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] ed;
    logic [31:0] ep;
    logic [31:0] ea;
    logic        eh;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic r, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] ed, input logic [31:0] ep,
                     input logic [31:0] ea, input logic eh);
    vec_t v;
    v.start = s; v.ready = r; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.ed = ed; v.ep = ep; v.ea = ea; v.eh = eh;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h1234_0000 + 32'(i);
    rom[5] = 32'hFFFF_FFFF;

    rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    redirect_valid4 = 1'b0; redirect_pc4 = '0;
    inst_ready = 1'b1; inst_ready4 = 1'b1;

    #12;
    check("rst_valid",  {31'b0, inst_valid}, 32'h0);
    check("rst_data",   inst_data, 32'h0);
    check("rst_pc",     inst_pc,   32'h0);
    check("rst_addr",   imem_addr, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_perf_f", perf_fetch_cnt, 32'h0);
    check("rst_perf_s", perf_stall_cnt, 32'h0);
    tick;
    rst_n = 1'b1;
    tick;

    //   start ready rv rpc        ev  data            pc     addr   halted
    add(1, 1, 0, 32'h0,  0, 32'h0,          32'h0,  32'h0,  0);  // 0: IDLE->RUN
    add(0, 1, 0, 32'h0,  1, 32'h1234_0000,  32'h0,  32'h4,  0);  // 1: first word
    add(0, 1, 0, 32'h0,  1, 32'h1234_0001,  32'h4,  32'h8,  0);
    add(0, 1, 0, 32'h0,  1, 32'h1234_0002,  32'h8,  32'hC,  0);
    add(0, 1, 0, 32'h0,  1, 32'h1234_0003,  32'hC,  32'h10, 0);
    add(0, 1, 0, 32'h0,  1, 32'h1234_0004,  32'h10, 32'h14, 0);
    add(0, 1, 0, 32'h0,  1, 32'hFFFF_FFFF,  32'h14, 32'h14, 1);  // 6: halt word pushed
    add(0, 1, 0, 32'h0,  0, 32'h0,          32'h0,  32'h14, 1);  // 7: drained
    add(1, 1, 0, 32'h0,  0, 32'h0,          32'h0,  32'h14, 1);  // 8: start ignored in HALT
    add(0, 1, 1, 32'h0,  0, 32'h0,          32'h0,  32'h0,  0);  // 9: redirect to 0
    add(0, 0, 0, 32'h0,  1, 32'h1234_0000,  32'h0,  32'h4,  0);  // 10: resumed
    add(0, 0, 0, 32'h0,  1, 32'h1234_0000,  32'h0,  32'h8,  0);  // 11..15 stalled
    add(0, 0, 0, 32'h0,  1, 32'h1234_0000,  32'h0,  32'h8,  0);
    add(0, 0, 0, 32'h0,  1, 32'h1234_0000,  32'h0,  32'h8,  0);
    add(0, 0, 0, 32'h0,  1, 32'h1234_0000,  32'h0,  32'h8,  0);
    add(0, 0, 0, 32'h0,  1, 32'h1234_0000,  32'h0,  32'h8,  0);
    add(0, 1, 0, 32'h0,  1, 32'h1234_0001,  32'h4,  32'h8,  0);  // 16: pop only, no same-cycle refill
    add(0, 1, 0, 32'h0,  1, 32'h1234_0002,  32'h8,  32'hC,  0);
    add(0, 1, 0, 32'h0,  1, 32'h1234_0003,  32'hC,  32'h10, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      start          = vecs[i].start;
      inst_ready     = vecs[i].ready;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      tick;
      check($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].ev});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].ea);
      check($sformatf("v%0d_halted", i), {31'b0, halted}, {31'b0, vecs[i].eh});
      if (vecs[i].ev) begin
        check($sformatf("v%0d_data", i), inst_data, vecs[i].ed);
        check($sformatf("v%0d_pc", i), inst_pc, vecs[i].ep);
      end
    end
    start = 1'b0;

`ifdef IFETCH_PERF_EN
    check("perf_fetch", perf_fetch_cnt, 32'd10);
    check("perf_stall", perf_stall_cnt, 32'd5);
`else
    check("perf_fetch_tied", perf_fetch_cnt, 32'h0);
    check("perf_stall_tied", perf_stall_cnt, 32'h0);
`endif

    // The FIFO fills to two entries. Then an odd-address redirect flushes it.
    inst_ready = 1'b0;
    tick;
    tick;
    check("full_head_pc", inst_pc,   32'hC);
    check("full_addr",    imem_addr, 32'h14);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h41;
    tick;
    redirect_valid = 1'b0;
    check("redir_valid", {31'b0, inst_valid}, 32'h0);
    check("redir_addr",  imem_addr, 32'h40);
    tick;
    check("redir_first_valid", {31'b0, inst_valid}, 32'h1);
    check("redir_first_pc",    inst_pc,   32'h40);
    check("redir_first_data",  inst_data, 32'h1234_0010);
    tick;
    check("refill_addr", imem_addr, 32'h48);

    // An asynchronous reset in mid-cycle with a full FIFO takes effect without a clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_valid",  {31'b0, inst_valid}, 32'h0);
    check("arst_data",   inst_data, 32'h0);
    check("arst_pc",     inst_pc,   32'h0);
    check("arst_addr",   imem_addr, 32'h0);
    check("arst_halted", {31'b0, halted}, 32'h0);
    tick;
    rst_n = 1'b1;
    inst_ready = 1'b1;
    tick;

    // With a 4-word ROM, words 0..3 are delivered. Then PC 0x10 halts without a push.
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    check("m4_valid0", {31'b0, inst_valid4}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check($sformatf("m4_w%0d_valid", i), {31'b0, inst_valid4}, 32'h1);
      check($sformatf("m4_w%0d_pc", i),    inst_pc4,   32'(4 * i));
      check($sformatf("m4_w%0d_data", i),  inst_data4, 32'h1234_0000 + 32'(i));
    end
    check("m4_addr_end", imem_addr4, 32'h10);
    tick;
    check("m4_halted",   {31'b0, halted4}, 32'h1);
    check("m4_drained",  {31'b0, inst_valid4}, 32'h0);
    check("m4_addr_hold", imem_addr4, 32'h10);
    tick;
    check("m4_no_push", {31'b0, inst_valid4}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
